// File: rtl/dds_pkg.sv
// Shared constants, sweep modes and FSM state type for the DDS sweep controller.
package dds_pkg;

  localparam int FW_W    = 32;
  localparam int DWELL_W = 16;

  localparam logic [FW_W-1:0] DEF_FW = 32'd21474836;

  localparam logic [1:0] MODE_SINGLE = 2'd0;
  localparam logic [1:0] MODE_SAW    = 2'd1;
  localparam logic [1:0] MODE_TRI    = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN_UP = 2'd1,
    ST_RUN_DN = 2'd2,
    ST_DONE   = 2'd3
  } sweep_state_t;

  // A sweep needs a nonzero step, an ordered range and a defined mode.
  function automatic logic cfg_is_valid(
    input logic [FW_W-1:0] start,
    input logic [FW_W-1:0] stop,
    input logic [FW_W-1:0] step,
    input logic [1:0]      mode
  );
    return (step != '0) && (start <= stop) && (mode != 2'd3);
  endfunction

endpackage

// File: rtl/dds_sweep_ctrl_if.sv
// Configuration, control and tuning-word signals of the DDS sweep controller.
interface dds_sweep_ctrl_if;
  import dds_pkg::*;

  // Config handshake: a config transfers on a cycle where cfg_valid && cfg_ready
  // at the rising edge; the master holds all cfg_* fields stable while cfg_valid
  // is high, and cfg_ready never depends combinationally on cfg_valid.
  logic               cfg_valid;
  logic               cfg_ready;
  logic [FW_W-1:0]    cfg_start;
  logic [FW_W-1:0]    cfg_stop;
  logic [FW_W-1:0]    cfg_step;
  logic [DWELL_W-1:0] cfg_dwell;
  logic [1:0]         cfg_mode;
  logic               cfg_err;
  logic               start;
  logic               abort;
  logic [FW_W-1:0]    freq_word;
  logic               freq_valid;
  logic               busy;
  logic               sweep_done;
  sweep_state_t       dbg_state;

  modport master (
    output cfg_valid, cfg_start, cfg_stop, cfg_step, cfg_dwell, cfg_mode,
    output start, abort,
    input  cfg_ready, cfg_err, freq_word, freq_valid, busy, sweep_done, dbg_state
  );

  modport slave (
    input  cfg_valid, cfg_start, cfg_stop, cfg_step, cfg_dwell, cfg_mode,
    input  start, abort,
    output cfg_ready, cfg_err, freq_word, freq_valid, busy, sweep_done, dbg_state
  );

endinterface

// File: rtl/dds_dwell_timer.sv
// Loadable down-counter; done is high while the count is zero.
module dds_dwell_timer
  import dds_pkg::*;
(
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic               load,
  input  logic [DWELL_W-1:0] value,
  output logic               done
);

  localparam logic [DWELL_W-1:0] ONE = 1;

  logic [DWELL_W-1:0] r_cnt;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= value;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - ONE;
    end
  end

  assign done = (r_cnt == '0);

endmodule

// File: rtl/dds_sweep_ctrl.sv
// DDS tuning-word scheduler: single, sawtooth and triangle sweeps between
// shadow start/stop words, each point held for dwell+1 cycles.
module dds_sweep_ctrl
  import dds_pkg::*;
(
  input  logic             sys_clk,
  input  logic             sys_rst,
  dds_sweep_ctrl_if.slave  bus
);

  sweep_state_t       r_state;
  sweep_state_t       w_state_nxt;
  logic               r_init;
  logic [FW_W-1:0]    r_start;
  logic [FW_W-1:0]    r_stop;
  logic [FW_W-1:0]    r_step;
  logic [DWELL_W-1:0] r_dwell;
  logic [1:0]         r_mode;
  logic [FW_W-1:0]    r_fw;
  logic               r_fv;
  logic               r_err;

  logic               w_go;
  logic               w_xfer;
  logic               w_cfg_ok;
  logic               w_dwell_done;
  logic [FW_W:0]      w_up_sum;
  logic [FW_W:0]      w_dn_diff;
  logic               w_up_lim;
  logic               w_dn_lim;
  logic [FW_W-1:0]    w_fw_nxt;
  logic               w_fw_upd;

  assign w_go     = bus.start && !bus.abort;
  assign w_xfer   = bus.cfg_valid && bus.cfg_ready;
  assign w_cfg_ok = cfg_is_valid(bus.cfg_start, bus.cfg_stop, bus.cfg_step, bus.cfg_mode);

  // Extra MSB catches wrap past the top of the word range and borrow below zero.
  assign w_up_sum  = {1'b0, r_fw} + {1'b0, r_step};
  assign w_dn_diff = {1'b0, r_fw} - {1'b0, r_step};
  assign w_up_lim  = w_up_sum[FW_W]  || (w_up_sum[FW_W-1:0]  > r_stop);
  assign w_dn_lim  = w_dn_diff[FW_W] || (w_dn_diff[FW_W-1:0] < r_start);

  dds_dwell_timer u_dwell (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .load    (w_fw_upd),
    .value   (r_dwell),
    .done    (w_dwell_done)
  );

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_go) w_state_nxt = ST_RUN_UP;
      ST_RUN_UP: begin
        if (bus.abort) begin
          w_state_nxt = ST_IDLE;
        end else if (w_dwell_done && w_up_lim) begin
          if (r_mode == MODE_SINGLE)   w_state_nxt = ST_DONE;
          else if (r_mode == MODE_TRI) w_state_nxt = ST_RUN_DN;
        end
      end
      ST_RUN_DN: begin
        if (bus.abort)                      w_state_nxt = ST_IDLE;
        else if (w_dwell_done && w_dn_lim)  w_state_nxt = ST_RUN_UP;
      end
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.cfg_ready  = (r_state == ST_IDLE) && r_init;
    bus.busy       = (r_state == ST_RUN_UP) || (r_state == ST_RUN_DN);
    bus.sweep_done = (r_state == ST_DONE);
    bus.dbg_state  = r_state;
  end

  // Next tuning word; a clamp to start only triggers for a single-point triangle.
  always_comb begin
    w_fw_nxt = r_fw;
    w_fw_upd = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_go) begin
          w_fw_nxt = r_start;
          w_fw_upd = 1'b1;
        end
      end
      ST_RUN_UP: begin
        if (!bus.abort && w_dwell_done) begin
          if (!w_up_lim) begin
            w_fw_nxt = w_up_sum[FW_W-1:0];
            w_fw_upd = 1'b1;
          end else if (r_mode == MODE_SAW) begin
            w_fw_nxt = r_start;
            w_fw_upd = 1'b1;
          end else if (r_mode == MODE_TRI) begin
            w_fw_nxt = w_dn_lim ? r_start : w_dn_diff[FW_W-1:0];
            w_fw_upd = 1'b1;
          end
        end
      end
      ST_RUN_DN: begin
        if (!bus.abort && w_dwell_done) begin
          w_fw_upd = 1'b1;
          if (!w_dn_lim) w_fw_nxt = w_dn_diff[FW_W-1:0];
          else           w_fw_nxt = w_up_lim ? r_start : w_up_sum[FW_W-1:0];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_init <= 1'b0;
      r_fw   <= '0;
      r_fv   <= 1'b0;
    end else begin
      r_init <= 1'b1;
      r_fv   <= w_fw_upd;
      if (w_fw_upd) r_fw <= w_fw_nxt;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_start <= DEF_FW;
      r_stop  <= DEF_FW;
      r_step  <= FW_W'(1);
      r_dwell <= '0;
      r_mode  <= MODE_SINGLE;
      r_err   <= 1'b0;
    end else begin
      r_err <= w_xfer && !w_cfg_ok;
      if (w_xfer && w_cfg_ok) begin
        r_start <= bus.cfg_start;
        r_stop  <= bus.cfg_stop;
        r_step  <= bus.cfg_step;
        r_dwell <= bus.cfg_dwell;
        r_mode  <= bus.cfg_mode;
      end
    end
  end

  assign bus.freq_word  = r_fw;
  assign bus.freq_valid = r_fv;
  assign bus.cfg_err    = r_err;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Bench for dds_sweep_ctrl: directed scenarios plus randomized sweeps checked
// against a point-list model of the sweep schedule.
module tb_dds_sweep_ctrl;
  import dds_pkg::*;

  localparam int W = FW_W + 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dds_sweep_ctrl_if bus();

  dds_sweep_ctrl dut (
    .sys_clk (clk),
    .sys_rst (rst),
    .bus     (bus)
  );

  logic [W-1:0] exp_q[$];
  logic [W-1:0] w_obs;
  int n_checks = 0;
  int n_pass   = 0;

  assign w_obs = {bus.freq_word, bus.freq_valid, bus.busy, bus.sweep_done};

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected per-cycle {freq_word, freq_valid, busy, sweep_done} from cycle 1
  // after start: sweep points are start + k*step up to stop, visited in order
  // (single/saw) or bouncing between the ends (triangle), each for dw+1 cycles.
  task automatic build_exp(input logic [FW_W-1:0] s, input logic [FW_W-1:0] t,
                           input logic [FW_W-1:0] st, input int dw, input int md,
                           input int ncyc);
    logic [FW_W-1:0] pts[$];
    longint v, tv, sv;
    int n, k, idx, m;
    exp_q.delete();
    v  = {32'd0, s};
    tv = {32'd0, t};
    sv = {32'd0, st};
    while (v <= tv) begin
      pts.push_back(v[FW_W-1:0]);
      v = v + sv;
    end
    n = pts.size();
    k = 0;
    while (exp_q.size() < ncyc) begin
      if (md == 0 && k == n) begin
        exp_q.push_back({pts[n-1], 3'b001});
        while (exp_q.size() < ncyc) exp_q.push_back({pts[n-1], 3'b000});
      end else begin
        if (md == 0)      idx = k;
        else if (md == 1) idx = k % n;
        else if (n == 1)  idx = 0;
        else begin
          m   = k % (2 * n - 2);
          idx = (m < n) ? m : (2 * n - 2 - m);
        end
        for (int d = 0; d <= dw; d++)
          exp_q.push_back({pts[idx], (d == 0) ? 1'b1 : 1'b0, 1'b1, 1'b0});
        k++;
      end
    end
  endtask

  task automatic cfg_load(input logic [FW_W-1:0] s, input logic [FW_W-1:0] t,
                          input logic [FW_W-1:0] st, input int dw, input int md,
                          output logic err_seen);
    int guard;
    guard = 0;
    @(negedge clk);
    bus.cfg_start = s;
    bus.cfg_stop  = t;
    bus.cfg_step  = st;
    bus.cfg_dwell = DWELL_W'(dw);
    bus.cfg_mode  = 2'(md);
    bus.cfg_valid = 1'b1;
    while (!bus.cfg_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard == 50) begin
      n_checks++;
      $display("FAIL cfg_ready_timeout: cfg_ready=%0b required 1", bus.cfg_ready);
    end
    @(negedge clk);
    bus.cfg_valid = 1'b0;
    err_seen = bus.cfg_err;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++;
    if ({w_obs, bus.cfg_err, bus.cfg_ready} !== {{FW_W{1'b0}}, 5'b0}) begin
      $display("FAIL reset_values: fw=%0h v/b/d=%03b err=%0b rdy=%0b required all 0",
               bus.freq_word, w_obs[2:0], bus.cfg_err, bus.cfg_ready);
    end else n_pass++;
    rst = 1'b0;
    #1;
    n_checks++;
    if (bus.cfg_ready !== 1'b0) $display("FAIL ready_at_release: %0b required 0", bus.cfg_ready);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (bus.cfg_ready !== 1'b1) $display("FAIL ready_after_clock: %0b required 1", bus.cfg_ready);
    else n_pass++;
  endtask

  task automatic test_single_dwell();
    logic err;
    logic [W-1:0] e;
    cfg_load(32'd100, 32'd130, 32'd10, 2, 0, err);
    n_checks++;
    if (err !== 1'b0) $display("FAIL single_cfg_err: %0b required 0", err);
    else n_pass++;
    build_exp(32'd100, 32'd130, 32'd10, 2, 0, 16);
    @(negedge clk);
    bus.start = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      e = exp_q.pop_front();
      n_checks++;
      if (w_obs !== e) $display("FAIL single_c%0d: got %0h/%03b required %0h/%03b",
                                c, w_obs[W-1:3], w_obs[2:0], e[W-1:3], e[2:0]);
      else n_pass++;
    end
  endtask

  task automatic test_triangle();
    logic err;
    logic [W-1:0] e;
    cfg_load(32'd100, 32'd130, 32'd10, 0, 2, err);
    n_checks++;
    if (err !== 1'b0) $display("FAIL tri_cfg_err: %0b required 0", err);
    else n_pass++;
    build_exp(32'd100, 32'd130, 32'd10, 0, 2, 20);
    @(negedge clk);
    bus.start = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      e = exp_q.pop_front();
      n_checks++;
      if (w_obs !== e) $display("FAIL tri_c%0d: got %0h/%03b required %0h/%03b",
                                c, w_obs[W-1:3], w_obs[2:0], e[W-1:3], e[2:0]);
      else n_pass++;
    end
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    n_checks++;
    if ({bus.busy, bus.sweep_done, bus.cfg_ready} !== 3'b001)
      $display("FAIL tri_abort: busy/done/rdy=%03b required 001",
               {bus.busy, bus.sweep_done, bus.cfg_ready});
    else n_pass++;
  endtask

  task automatic test_top_wrap();
    logic err;
    logic [W-1:0] e;
    cfg_load(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h10, 0, 0, err);
    build_exp(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h10, 0, 0, 4);
    @(negedge clk);
    bus.start = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      e = exp_q.pop_front();
      n_checks++;
      if (w_obs !== e) $display("FAIL wrap_c%0d: got %0h/%03b required %0h/%03b",
                                c, w_obs[W-1:3], w_obs[2:0], e[W-1:3], e[2:0]);
      else n_pass++;
    end
  endtask

  task automatic test_bad_cfg();
    logic err;
    logic [W-1:0] e;
    cfg_load(32'd5, 32'd50, 32'd0, 1, 0, err);
    n_checks++;
    if (err !== 1'b1) $display("FAIL bad_step_err: %0b required 1", err);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (bus.cfg_err !== 1'b0) $display("FAIL err_pulse_width: %0b required 0", bus.cfg_err);
    else n_pass++;
    cfg_load(32'd60, 32'd50, 32'd1, 0, 0, err);
    n_checks++;
    if (err !== 1'b1) $display("FAIL bad_order_err: %0b required 1", err);
    else n_pass++;
    cfg_load(32'd0, 32'd10, 32'd1, 0, 3, err);
    n_checks++;
    if (err !== 1'b1) $display("FAIL bad_mode_err: %0b required 1", err);
    else n_pass++;
    build_exp(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h10, 0, 0, 3);
    @(negedge clk);
    bus.start = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      e = exp_q.pop_front();
      n_checks++;
      if (w_obs !== e) $display("FAIL bad_keep_c%0d: got %0h/%03b required %0h/%03b",
                                c, w_obs[W-1:3], w_obs[2:0], e[W-1:3], e[2:0]);
      else n_pass++;
    end
  endtask

  task automatic test_abort();
    logic err;
    logic [W-1:0] e;
    logic [FW_W-1:0] last_fw;
    cfg_load(32'd100, 32'd130, 32'd10, 1, 1, err);
    build_exp(32'd100, 32'd130, 32'd10, 1, 1, 5);
    last_fw = '0;
    @(negedge clk);
    bus.start = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      last_fw = e[W-1:3];
      n_checks++;
      if (w_obs !== e) $display("FAIL abort_c%0d: got %0h/%03b required %0h/%03b",
                                c, w_obs[W-1:3], w_obs[2:0], e[W-1:3], e[2:0]);
      else n_pass++;
    end
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    bus.start = 1'b0;
    n_checks++;
    if ({w_obs, bus.cfg_ready} !== {last_fw, 3'b000, 1'b1})
      $display("FAIL abort_c6: got %0h/%03b rdy=%0b required %0h/000 rdy=1",
               w_obs[W-1:3], w_obs[2:0], bus.cfg_ready, last_fw);
    else n_pass++;
    for (int c = 7; c <= 9; c++) begin
      @(negedge clk);
      n_checks++;
      if ({bus.busy, bus.sweep_done} !== 2'b00)
        $display("FAIL abort_quiet_c%0d: busy/done=%02b required 00", c, {bus.busy, bus.sweep_done});
      else n_pass++;
    end
  endtask

  task automatic test_random();
    logic err;
    logic [W-1:0] e;
    logic [FW_W-1:0] s, t, st;
    longint tt;
    int dw, md;
    for (int it = 0; it < 10; it++) begin
      s  = ($urandom_range(0, 2) == 0) ? (32'hFFFF_FFFF - $urandom_range(0, 40)) : $urandom;
      tt = {32'd0, s} + longint'($urandom_range(0, 60));
      t  = (tt > 64'h0000_0000_FFFF_FFFF) ? 32'hFFFF_FFFF : tt[FW_W-1:0];
      st = $urandom_range(1, 25);
      dw = $urandom_range(0, 3);
      md = $urandom_range(0, 2);
      cfg_load(s, t, st, dw, md, err);
      n_checks++;
      if (err !== 1'b0) $display("FAIL rnd%0d_cfg_err: %0b required 0", it, err);
      else n_pass++;
      build_exp(s, t, st, dw, md, 40);
      @(negedge clk);
      bus.start = 1'b1;
      for (int c = 1; c <= 40; c++) begin
        @(negedge clk);
        e = exp_q.pop_front();
        n_checks++;
        if (w_obs !== e)
          $display("FAIL rnd%0d_c%0d: got %0h/%03b required %0h/%03b (s=%0h t=%0h st=%0h dw=%0d md=%0d)",
                   it, c, w_obs[W-1:3], w_obs[2:0], e[W-1:3], e[2:0], s, t, st, dw, md);
        else n_pass++;
        // start and config offers while running must have no effect
        bus.start     = e[1] ? 1'($urandom_range(0, 1)) : 1'b0;
        bus.cfg_valid = e[1] ? 1'($urandom_range(0, 1)) : 1'b0;
        bus.cfg_start = $urandom;
        bus.cfg_stop  = $urandom;
        bus.cfg_step  = $urandom_range(0, 3);
        bus.cfg_mode  = 2'($urandom_range(0, 3));
      end
      bus.start     = 1'b0;
      bus.cfg_valid = 1'b0;
      bus.abort     = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
      n_checks++;
      if ({bus.busy, bus.cfg_err} !== 2'b00)
        $display("FAIL rnd%0d_end: busy/err=%02b required 00", it, {bus.busy, bus.cfg_err});
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    logic err;
    logic [W-1:0] e;
    cfg_load(32'd1000, 32'd2000, 32'd7, 0, 1, err);
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({bus.freq_word, bus.freq_valid, bus.busy, bus.cfg_ready} !== {{FW_W{1'b0}}, 3'b000})
      $display("FAIL async_reset: fw=%0h v/b/rdy=%03b required 0/000",
               bus.freq_word, {bus.freq_valid, bus.busy, bus.cfg_ready});
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.cfg_ready !== 1'b1) $display("FAIL ready_after_reset: %0b required 1", bus.cfg_ready);
    else n_pass++;
    build_exp(DEF_FW, DEF_FW, 32'd1, 0, 0, 3);
    bus.start = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      e = exp_q.pop_front();
      n_checks++;
      if (w_obs !== e) $display("FAIL default_c%0d: got %0h/%03b required %0h/%03b",
                                c, w_obs[W-1:3], w_obs[2:0], e[W-1:3], e[2:0]);
      else n_pass++;
    end
  endtask

  initial begin
    bus.cfg_valid = 1'b0;
    bus.cfg_start = '0;
    bus.cfg_stop  = '0;
    bus.cfg_step  = '0;
    bus.cfg_dwell = '0;
    bus.cfg_mode  = '0;
    bus.start     = 1'b0;
    bus.abort     = 1'b0;
    test_reset();
    test_single_dwell();
    test_triangle();
    test_top_wrap();
    test_bad_cfg();
    test_abort();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
